// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot render path: framebuffer geometry
// defaults and the write-buffer bank state encoding.
package mandel_pkg;

    localparam int FB_W_DEFAULT = 960;
    localparam int FB_H_DEFAULT = 544;

    // Line RAM geometry: one 1024-byte line per bank, two banks.
    localparam int WB_AW = 10;
    localparam int WB_DW = 8;

    typedef enum logic [1:0] {
        EMPTY      = 2'd0,
        FILLING    = 2'd1,
        FULL       = 2'd2,
        COMMITTING = 2'd3
    } wb_state_t;

    // A bank that can still take pixels from the renderer.
    function automatic logic wb_accepts(input wb_state_t s);
        return (s == EMPTY) || (s == FILLING);
    endfunction

    // A bank holding a complete line, including while the DMA drains it.
    function automatic logic wb_holds_line(input wb_state_t s);
        return (s == FULL) || (s == COMMITTING);
    endfunction

endpackage

// File: rtl/render_line_wbuf_ram.sv
// Two-bank line RAM: one write port from the renderer, one registered
// read port toward the DMA. Read-during-write to the same word returns
// the previous contents.
module wbuf_ram
    import mandel_pkg::*;
#(
    parameter int AW = WB_AW,
    parameter int DW = WB_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int DEPTH = 2 * (2 ** AW);

    logic [DW-1:0] mem [0:DEPTH-1];

    // Write port: contents are never reset, stale data is simply overwritten.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    // Read port: free-running registered read, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end

endmodule

// File: rtl/render_line_wbuf.sv
// Ping-pong line write-buffer between the pixel engine and the SRAM line
// DMA. Each bank collects one full line, is handed to the DMA, and is
// released back to the renderer when the DMA signals it is done.
module render_line_wbuf
    import mandel_pkg::*;
#(
    parameter int FB_W = FB_W_DEFAULT,
    parameter int FB_H = FB_H_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       px_valid,
    output logic       px_ready,
    input  logic [9:0] px_x,
    input  logic [9:0] px_y,
    input  logic [7:0] px_iter,
    input  logic       restart,
    input  logic       rb_bank,
    input  logic [9:0] rb_addr,
    output logic [7:0] rb_data,
    output logic       wb_full0,
    output logic       wb_full1,
    output logic [9:0] wb_y0,
    output logic [9:0] wb_y1,
    input  logic       commit_take,
    input  logic       commit_done,
    input  logic       commit_bank,
    output logic       frame_done,
    output logic       seq_err,
    output logic       proto_err
);

    localparam logic [9:0] LAST_X = 10'(FB_W - 1);
    localparam logic [9:0] LAST_Y = 10'(FB_H - 1);

    wb_state_t   st_q [2];
    wb_state_t   st_d [2];
    logic [9:0]  wb_y_q [2];
    logic [9:0]  wb_y_d [2];
    logic        fill_bank_q, fill_bank_d;
    logic [10:0] fill_idx_q, fill_idx_d;
    logic        seq_err_q, seq_err_d;
    logic        proto_err_q, proto_err_d;
    logic        frame_done_q, frame_done_d;
    logic        px_acc;

    // Ready depends only on registered state, so no combinational path
    // from px_valid back to px_ready. A restart cycle never accepts.
    assign px_ready = wb_accepts(st_q[fill_bank_q]);
    assign px_acc   = px_valid & px_ready & ~restart;

    wbuf_ram #(
        .AW (WB_AW),
        .DW (WB_DW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (px_acc),
        .wr_bank (fill_bank_q),
        .wr_addr (px_x),
        .wr_data (px_iter),
        .rd_bank (rb_bank),
        .rd_addr (rb_addr),
        .rd_data (rb_data)
    );

    // Next-state: fill-side events act on fill_bank, DMA events act on
    // commit_bank; both are judged against the current registered state.
    always_comb begin
        st_d[0]      = st_q[0];
        st_d[1]      = st_q[1];
        wb_y_d[0]    = wb_y_q[0];
        wb_y_d[1]    = wb_y_q[1];
        fill_bank_d  = fill_bank_q;
        fill_idx_d   = fill_idx_q;
        seq_err_d    = seq_err_q;
        proto_err_d  = proto_err_q;
        frame_done_d = 1'b0;

        if (restart) begin
            // Only a partial line is abandoned; complete lines are kept.
            if (st_q[fill_bank_q] == FILLING) begin
                st_d[fill_bank_q] = EMPTY;
                fill_idx_d        = '0;
            end
        end else if (px_acc) begin
            if ({1'b0, px_x} != fill_idx_q) begin
                seq_err_d = 1'b1;
            end
            if (st_q[fill_bank_q] == EMPTY) begin
                st_d[fill_bank_q]   = FILLING;
                wb_y_d[fill_bank_q] = px_y;
            end
            fill_idx_d = {1'b0, px_x} + 11'd1;
            if (px_x == LAST_X) begin
                st_d[fill_bank_q] = FULL;
                fill_bank_d       = ~fill_bank_q;
                fill_idx_d        = '0;
            end
        end

        if (commit_take) begin
            if (st_q[commit_bank] == FULL) begin
                st_d[commit_bank] = COMMITTING;
            end else begin
                proto_err_d = 1'b1;
            end
        end

        if (commit_done) begin
            if (st_q[commit_bank] == COMMITTING) begin
                st_d[commit_bank] = EMPTY;
                if (wb_y_q[commit_bank] == LAST_Y) begin
                    frame_done_d = 1'b1;
                end
            end else begin
                proto_err_d = 1'b1;
            end
        end
    end

    // State register: everything here is control, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q[0]      <= EMPTY;
            st_q[1]      <= EMPTY;
            wb_y_q[0]    <= '0;
            wb_y_q[1]    <= '0;
            fill_bank_q  <= 1'b0;
            fill_idx_q   <= '0;
            seq_err_q    <= 1'b0;
            proto_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            st_q[0]      <= st_d[0];
            st_q[1]      <= st_d[1];
            wb_y_q[0]    <= wb_y_d[0];
            wb_y_q[1]    <= wb_y_d[1];
            fill_bank_q  <= fill_bank_d;
            fill_idx_q   <= fill_idx_d;
            seq_err_q    <= seq_err_d;
            proto_err_q  <= proto_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wb_full0   = wb_holds_line(st_q[0]);
    assign wb_full1   = wb_holds_line(st_q[1]);
    assign wb_y0      = wb_y_q[0];
    assign wb_y1      = wb_y_q[1];
    assign frame_done = frame_done_q;
    assign seq_err    = seq_err_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_render_line_wbuf.sv
// Bench for render_line_wbuf: directed scenarios plus a randomized stream,
// every cycle compared against a line-level reference model.
module tb_render_line_wbuf;

    localparam int FB_W = 960;
    localparam int FB_H = 544;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       px_valid = 1'b0;
    logic       px_ready;
    logic [9:0] px_x = '0;
    logic [9:0] px_y = '0;
    logic [7:0] px_iter = '0;
    logic       restart = 1'b0;
    logic       rb_bank = 1'b0;
    logic [9:0] rb_addr = '0;
    logic [7:0] rb_data;
    logic       wb_full0, wb_full1;
    logic [9:0] wb_y0, wb_y1;
    logic       commit_take = 1'b0;
    logic       commit_done = 1'b0;
    logic       commit_bank = 1'b0;
    logic       frame_done;
    logic       seq_err;
    logic       proto_err;

    always #5 clk = ~clk;

    render_line_wbuf #(.FB_W(FB_W), .FB_H(FB_H)) dut (
        .clk         (clk),
        .rst         (rst),
        .px_valid    (px_valid),
        .px_ready    (px_ready),
        .px_x        (px_x),
        .px_y        (px_y),
        .px_iter     (px_iter),
        .restart     (restart),
        .rb_bank     (rb_bank),
        .rb_addr     (rb_addr),
        .rb_data     (rb_data),
        .wb_full0    (wb_full0),
        .wb_full1    (wb_full1),
        .wb_y0       (wb_y0),
        .wb_y1       (wb_y1),
        .commit_take (commit_take),
        .commit_done (commit_done),
        .commit_bank (commit_bank),
        .frame_done  (frame_done),
        .seq_err     (seq_err),
        .proto_err   (proto_err)
    );

    // Reference model: bank status 0=empty 1=filling 2=full 3=committing.
    int         m_st [2];
    logic [9:0] m_y [2];
    int         m_fb;
    int         m_idx;
    bit         m_seq, m_proto, m_frame;
    logic [7:0] m_mem [2][1024];
    bit         m_wr [2][1024];
    logic [7:0] m_rb;
    bit         m_rb_known;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return m_st[m_fb] < 2;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_st[b] = 0;
            m_y[b]  = '0;
            for (int a = 0; a < 1024; a++) m_wr[b][a] = 1'b0;
        end
        m_fb = 0; m_idx = 0;
        m_seq = 0; m_proto = 0; m_frame = 0;
        m_rb = '0; m_rb_known = 1'b1;
    endtask

    // Apply the rules of one clock edge to the model, using the inputs
    // as they stand at that edge.
    task automatic model_edge();
        int         os [2];
        logic [9:0] oy [2];
        int         cb;
        bit         acc;
        os[0] = m_st[0]; os[1] = m_st[1];
        oy[0] = m_y[0];  oy[1] = m_y[1];
        m_rb_known = m_wr[rb_bank][rb_addr];
        m_rb       = m_mem[rb_bank][rb_addr];
        acc     = px_valid && m_ready() && !restart;
        m_frame = 0;
        if (restart) begin
            if (os[m_fb] == 1) begin
                m_st[m_fb] = 0;
                m_idx = 0;
            end
        end else if (acc) begin
            m_mem[m_fb][px_x] = px_iter;
            m_wr[m_fb][px_x]  = 1'b1;
            if (int'(px_x) != m_idx) m_seq = 1;
            if (os[m_fb] == 0) begin
                m_st[m_fb] = 1;
                m_y[m_fb]  = px_y;
            end
            m_idx = int'(px_x) + 1;
            if (int'(px_x) == FB_W - 1) begin
                m_st[m_fb] = 2;
                m_fb  = 1 - m_fb;
                m_idx = 0;
            end
        end
        cb = int'(commit_bank);
        if (commit_take) begin
            if (os[cb] == 2) m_st[cb] = 3;
            else m_proto = 1;
        end
        if (commit_done) begin
            if (os[cb] == 3) begin
                m_st[cb] = 0;
                if (int'(oy[cb]) == FB_H - 1) m_frame = 1;
            end else begin
                m_proto = 1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("px_ready", px_ready, m_ready());
        chk("wb_full0", wb_full0, m_st[0] >= 2);
        chk("wb_full1", wb_full1, m_st[1] >= 2);
        chk("wb_y0", wb_y0, m_y[0]);
        chk("wb_y1", wb_y1, m_y[1]);
        if (m_rb_known) chk("rb_data", rb_data, m_rb);
        chk("frame_done", frame_done, m_frame);
        chk("seq_err", seq_err, m_seq);
        chk("proto_err", proto_err, m_proto);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        px_valid = 0; restart = 0; commit_take = 0; commit_done = 0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_px_ready", px_ready, 1);
        chk("rst_wb_full0", wb_full0, 0);
        chk("rst_wb_full1", wb_full1, 0);
        chk("rst_wb_y0", wb_y0, 0);
        chk("rst_wb_y1", wb_y1, 0);
        chk("rst_rb_data", rb_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_seq_err", seq_err, 0);
        chk("rst_proto_err", proto_err, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [7:0] pat(input int x, input int y);
        return 8'((x ^ y) & 8'hFF);
    endfunction

    // Push pixels x0..x1-1 of line y, in order, waiting out stalls.
    task automatic send_span(input int x0, input int x1, input int y);
        int x = x0;
        int budget = 4 * (x1 - x0) + 16;
        while (x < x1 && budget > 0) begin
            bit rdy;
            px_valid = 1; px_x = 10'(x); px_y = 10'(y); px_iter = pat(x, y);
            rdy = m_ready();
            tick();
            if (rdy) x++;
            budget--;
        end
        px_valid = 0;
    endtask

    task automatic commit(input int b, input bit reads);
        commit_bank = 1'(b);
        commit_take = 1; tick(); commit_take = 0;
        if (reads) begin
            rb_bank = 1'(b);
            for (int a = 0; a < FB_W; a++) begin
                rb_addr = 10'(a);
                tick();
            end
            tick();
            chk("commit_hold_full", (b == 0) ? wb_full0 : wb_full1, 1);
        end
        commit_done = 1; tick(); commit_done = 0;
    endtask

    initial begin
        int cur_x, cur_y, dma_b, dma_left;
        model_reset();

        // Line y=5 in order, then a full DMA readback of bank 0.
        do_reset();
        send_span(0, FB_W, 5);
        chk("y5_full0", wb_full0, 1);
        chk("y5_wb_y0", wb_y0, 5);
        chk("y5_seq_err", seq_err, 0);
        chk("y5_ready_bank1", px_ready, 1);
        commit(0, 1);
        chk("y5_freed", wb_full0, 0);

        // Two lines without commits stall the renderer.
        do_reset();
        send_span(0, FB_W, 7);
        send_span(0, FB_W, 8);
        px_valid = 1; px_x = 0; px_y = 9;
        #1;
        chk("both_full_stall", px_ready, 0);
        px_valid = 0;
        commit(0, 0);
        tick();
        chk("bank0_freed", wb_full0, 0);
        chk("ready_after_free", px_ready, 1);
        commit(1, 0);

        // Partial line, restart with a pixel in the same cycle, then refill.
        send_span(0, 300, 19);
        px_valid = 1; px_x = 10'd300; px_y = 10'd19; px_iter = 8'hA5; restart = 1;
        tick();
        px_valid = 0; restart = 0;
        rb_bank = 0; rb_addr = 10'd300;
        tick();
        chk("restart_drop", rb_data, pat(300, 7));
        send_span(0, FB_W, 20);
        chk("refill_full0", wb_full0, 1);
        chk("refill_wb_y0", wb_y0, 20);
        chk("refill_seq_err", seq_err, 0);
        commit(0, 1);

        // Randomized traffic: gaps, rare restarts, DMA with random read bursts.
        do_reset();
        cur_x = 0; cur_y = $urandom_range(0, FB_H - 1); dma_b = -1; dma_left = 0;
        for (int c = 0; c < 7000; c++) begin
            bit acc_pred, rs;
            rs = ($urandom_range(0, 599) == 0);
            restart  = rs;
            px_valid = ($urandom_range(0, 9) < 8);
            px_x = 10'(cur_x); px_y = 10'(cur_y); px_iter = 8'($urandom);
            commit_take = 0; commit_done = 0;
            if (dma_b < 0) begin
                if ((m_st[0] == 2 || m_st[1] == 2) && $urandom_range(0, 3) == 0) begin
                    dma_b = (m_st[0] == 2) ? 0 : 1;
                    commit_bank = 1'(dma_b); commit_take = 1;
                    dma_left = $urandom_range(0, 1200);
                end
            end else if (dma_left == 0) begin
                commit_bank = 1'(dma_b); commit_done = 1;
                dma_b = -1;
            end else begin
                dma_left--;
            end
            rb_bank = (dma_b >= 0) ? 1'(dma_b) : 1'($urandom);
            rb_addr = 10'($urandom_range(0, 1023));
            acc_pred = px_valid && m_ready() && !rs;
            tick();
            if (rs) begin
                cur_x = 0; cur_y = $urandom_range(0, FB_H - 1);
            end else if (acc_pred) begin
                cur_x++;
                if (cur_x == FB_W) begin
                    cur_x = 0;
                    cur_y = ($urandom_range(0, 2) == 0) ? FB_H - 1 : $urandom_range(0, FB_H - 1);
                end
            end
        end
        idle_inputs();
        chk("rand_seq_clean", seq_err, 0);
        chk("rand_proto_clean", proto_err, 0);

        // Column skip 10->12 on the last frame line, then protocol error and frame end.
        do_reset();
        send_span(0, 11, FB_H - 1);
        send_span(12, FB_W, FB_H - 1);
        chk("skip_seq_err", seq_err, 1);
        send_span(0, 100, 3);
        chk("seq_err_sticky", seq_err, 1);
        commit_bank = 1; commit_done = 1; tick(); commit_done = 0;
        chk("done_on_filling_proto", proto_err, 1);
        commit_bank = 0; commit_take = 1; tick(); commit_take = 0;
        chk("take_no_frame", frame_done, 0);
        commit_done = 1; tick(); commit_done = 0;
        chk("frame_pulse", frame_done, 1);
        chk("frame_bank_free", wb_full0, 0);
        tick();
        chk("frame_pulse_end", frame_done, 0);
        send_span(100, FB_W, 3);
        chk("line3_full1", wb_full1, 1);
        send_span(0, 50, 4);

        // Done on an empty bank after a clean reset.
        do_reset();
        commit_bank = 1; commit_done = 1; tick(); commit_done = 0;
        chk("done_on_empty_proto", proto_err, 1);
        send_span(0, FB_W, 11);
        send_span(0, 200, 12);
        chk("pre_rst_full0", wb_full0, 1);

        // Mid-fill asynchronous reset clears everything immediately.
        do_reset();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL global_timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/render_line_wbuf.md
# render_line_wbuf

Ping-pong render write-buffer between the Mandelbrot pixel engine and the SRAM line DMA. Collects one full framebuffer line (FB_W iter8 bytes) per bank from the renderer and reports it as full with its line number. It then serves sequential reads to the DMA during a commit and frees the bank on `commit_done`. It provides the `wb_full*`/`wb_y*`/`rb_*` side of the DMA commit handshake.

## Interface
- `FB_W`, default 960: bytes per line; ≤ 1024.
- `FB_H`, default 544: lines per frame; `frame_done` keys on line `FB_H-1`.
- `clk` in 1: clk100, single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `px_valid` in 1: renderer pixel valid.
- `px_ready` out 1: pixel accepted when `px_valid & px_ready`.
- `px_x` in 10: pixel column.
- `px_y` in 10: pixel row.
- `px_iter` in 8: iteration byte.
- `restart` in 1: pulse; abandon the partially filled line.
- `rb_bank` in 1: DMA read bank.
- `rb_addr` in 10: DMA read address.
- `rb_data` out 8: registered read data, 1-cycle latency.
- `wb_full0`, `wb_full1` out 1: bank holds a complete line (FULL or COMMITTING).
- `wb_y0`, `wb_y1` out 10: line number of each bank.
- `commit_take` in 1: pulse; DMA starts reading `commit_bank`.
- `commit_done` in 1: pulse; DMA finished `commit_bank`.
- `commit_bank` in 1: bank qualifier for take/done.
- `frame_done` out 1: 1-cycle pulse when line `FB_H-1` is committed.
- `seq_err` out 1: sticky; out-of-order pixel.
- `proto_err` out 1: sticky; bad handshake.

## Operation
- Per-bank state: EMPTY → FILLING → FULL → COMMITTING → EMPTY.
- `fill_bank` register: the bank accepting pixels.
- `fill_idx` (11 bit): expected next column.
- `px_ready` = state[`fill_bank`] ∈ {EMPTY, FILLING}. It is combinational from registered state.
- Accepted pixel: written to RAM[`fill_bank`][`px_x`] regardless of order.
  - If `px_x != fill_idx`, set `seq_err`.
  - If the bank is EMPTY: bank → FILLING and `wb_y[fill_bank] <= px_y`.
  - `fill_idx <= px_x + 1`.
- Accepted pixel with `px_x == FB_W-1`: bank → FULL, `fill_bank` toggles, `fill_idx <= 0`.
- `restart`: if the fill bank is FILLING, it → EMPTY and `fill_idx <= 0`. FULL and COMMITTING banks are untouched.
  - `restart` coincident with an accepted pixel: `restart` wins and the pixel is dropped.
- `commit_take`: bank FULL → COMMITTING. Any other state sets `proto_err` with no state change.
- `commit_done`: bank COMMITTING → EMPTY. Any other state sets `proto_err`.
  - If `wb_y[commit_bank] == FB_H-1`, pulse `frame_done`.
- `wb_full[b]` = state ∈ {FULL, COMMITTING}. It stays high through the commit, so the DMA's fixed-priority select never sees a bank vanish mid-burst.
- Take/done and pixel events on different banks in the same cycle both apply.
- Done on bank b in the same cycle the fill bank toggles to b: b is EMPTY after the edge, and `px_ready` is high the next cycle.
- Read port: `rb_data <= RAM[rb_bank][rb_addr]` every cycle, with no enable, independent of bank state.

## Timing
- Reset values: all banks EMPTY; `fill_bank` = 0; `fill_idx` = 0; `wb_y*` = 0; `rb_data` = 0; `frame_done`, `seq_err`, `proto_err` = 0. `px_ready` = 1 after reset. `wb_full*` = 0.
- Reset mid-operation discards all line data and states. The DMA shares `rst`, so no handshake survives reset.
- Last pixel accepted at edge N: `wb_full` is high from cycle N+1.
- `commit_take` sampled at edge N: no visible output change.
- `commit_done` sampled at edge N: `wb_full` is low and `frame_done` pulses in cycle N+1.
- `rb_addr` presented in cycle N: data appears on `rb_data` in cycle N+1. RAM read-during-write returns old data; it cannot occur on a committing bank.
- Sustained throughput: 1 pixel/clk. Stall happens only while both banks are FULL/COMMITTING.

## Structure
- Shared package `mandel_pkg`:
  - `wb_state_t` enum (EMPTY, FILLING, FULL, COMMITTING).
  - `FB_W` / `FB_H` defaults shared with `sram_line_dma`.
- Sub-module `wbuf_ram`: simple dual-port BRAM, 2×1024×8.
  - Write port: bank/addr/data/we.
  - Read port: registered, bank/addr to data.
- FSM, counters and flags stay in the top.

## Test plan
- Reset, then 960 in-order pixels with y=5: `wb_full0`=1 and `wb_y0`=5 one cycle after the last pixel; `fill_bank`=1; `seq_err`=0.
- Fill both banks (y=7, y=8) without commits: `px_ready`=0 on the 1921st pixel. `commit_take`+`commit_done` on bank 0 gives `wb_full0`=0 and `px_ready`=1 the following cycle.
- DMA model reads bank 0 with `rb_addr` 0..959 after take: `rb_data` equals the written pattern (x^y)&0xFF with 1-cycle latency, and `wb_full0` holds 1 until done.
- 300 pixels, then `restart`, then a new line y=20: bank 0 refills and `wb_y0`=20. The restart-cycle pixel is not written.
- `px_x` skips 10→12: `seq_err` sticks at 1. `commit_done` on an EMPTY bank sets `proto_err`.
- Commit of line 543: `frame_done` pulses exactly one cycle. Assert `rst` mid-fill: all outputs return to reset values asynchronously.
